// File: rtl/pmem_responder.sv
// Cacheline memory responder: accepts one read or write at a time and answers
// with a single-cycle pmem_resp a fixed LATENCY cycles later.
//
// state | meaning
// IDLE  | no transaction; samples pmem_read/pmem_write for acceptance
// WAIT  | latency down-counter running toward terminal count
// RESP  | pmem_resp high for one cycle; a latched write commits on exit
module pmem_responder #(
    parameter int LATENCY     = 4,
    parameter int INDEX_WIDTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         busy,
    output logic         proto_err
);

    localparam int         LINES    = 1 << INDEX_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;
    logic [15:0]            addr_q, addr_d;
    logic [127:0]           wdata_q, wdata_d;
    logic [127:0]           rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   mem_we;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic [INDEX_WIDTH-1:0] idx_in;
    logic [127:0]           mem_q [LINES];

    assign idx_q  = addr_q[INDEX_WIDTH+3:4];
    assign idx_in = pmem_address[INDEX_WIDTH+3:4];

    // Offset and high address bits are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_read || pmem_write) begin
                    wr_d    = pmem_write;
                    rd_d    = pmem_read && !pmem_write;
                    addr_d  = pmem_address;
                    wdata_d = pmem_wdata;
                    cnt_d   = CNT_LOAD;
                    if (pmem_read && pmem_write) err_d = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        if (pmem_read && !pmem_write) rdata_d = mem_q[idx_in];
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!pmem_read && !pmem_write) err_d = 1'b1;
                // Terminal count: the counter lands on zero as RESP is entered.
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    if (rd_q) rdata_d = mem_q[idx_q];
                end
            end
            RESP: begin
                state_d = IDLE;
                mem_we  = wr_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= 16'h0;
            wdata_q <= 128'h0;
            rdata_q <= 128'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Line storage survives reset; reset only suppresses a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem_q[idx_q] <= wdata_q;
    end

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: stimulus pushes expected read data into a
// queue, a negedge monitor pops and compares whenever pmem_resp is seen.
module tb_pmem_responder;

    localparam int LAT = 4;

    localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] D3 = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [127:0] D4 = 128'h4040_4040_0F0F_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] D5 = 128'hA5A5_5A5A_0100_0100_C3C3_3C3C_7777_8888;
    localparam logic [127:0] D6 = 128'h7070_7070_6666_5555_4444_3333_2222_1111;

    logic         clk = 1'b0;
    logic         reset;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;
    logic         proto_err;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(LAT), .INDEX_WIDTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .busy         (busy),
        .proto_err    (proto_err)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] exp_q[$];
    logic [127:0] model_mem [16];
    logic [127:0] model_rdata;
    logic [127:0] mon_exp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pmem_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: pmem_resp=1 with nothing outstanding, required 0");
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp_rdata", pmem_rdata, mon_exp);
            end
        end
    end

    // Called at a negedge: drives the request and records the expected result.
    task automatic drive_req(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [127:0] data);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = data;
        if (wr) begin
            exp_q.push_back(model_rdata);
            model_mem[addr[7:4]] = data;
        end else begin
            model_rdata = model_mem[addr[7:4]];
            exp_q.push_back(model_rdata);
        end
    endtask

    task automatic await_resp(input bit withdraw, input bit scramble);
        int k;
        @(posedge clk);
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1 && scramble) begin
                pmem_address = ~pmem_address;
                pmem_wdata   = ~pmem_wdata;
            end
            if (k == 1 && withdraw) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            chk("busy_in_flight", busy, 1'b1);
            if (pmem_resp === 1'b1) break;
        end
        chk("resp_latency", k, LAT);
    endtask

    task automatic release_req();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        chk("resp_single_pulse", pmem_resp, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_rdata = 128'h0;
    endtask

    initial begin
        reset        = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0;
        pmem_wdata   = 128'h0;
        model_rdata  = 128'h0;
        for (int i = 0; i < 16; i++) model_mem[i] = 128'h0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_resp", pmem_resp, 1'b0);
        chk("reset_proto_err", proto_err, 1'b0);
        chk("reset_rdata", pmem_rdata, 128'h0);
        reset = 1'b0;
        @(negedge clk);

        // Write then read the same line; inputs scrambled after acceptance.
        drive_req(1'b0, 1'b1, 16'h0030, D1);
        await_resp(1'b0, 1'b1);
        release_req();
        chk("write_keeps_rdata", pmem_rdata, 128'h0);
        drive_req(1'b1, 1'b0, 16'h0035, 128'h0);
        await_resp(1'b0, 1'b1);
        release_req();
        repeat (3) @(negedge clk);
        chk("rdata_held", pmem_rdata, D1);

        // Reset two cycles into a write aborts it; line keeps old contents.
        drive_req(1'b0, 1'b1, 16'h0050, D2);
        await_resp(1'b0, 1'b0);
        release_req();
        pmem_write   = 1'b1;
        pmem_address = 16'h0050;
        pmem_wdata   = D3;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        reset      = 1'b1;
        pmem_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_rdata = 128'h0;
        chk("abort_busy_after", busy, 1'b0);
        chk("abort_rdata_reset", pmem_rdata, 128'h0);
        repeat (6) @(negedge clk);
        drive_req(1'b1, 1'b0, 16'h0050, 128'h0);
        await_resp(1'b0, 1'b0);
        release_req();
        chk("abort_prior_contents", pmem_rdata, D2);

        // Read and write together: write only, sticky proto_err.
        chk("proto_err_clear", proto_err, 1'b0);
        drive_req(1'b1, 1'b1, 16'h0040, D4);
        await_resp(1'b0, 1'b0);
        release_req();
        chk("both_proto_err", proto_err, 1'b1);
        chk("both_no_rdata_update", pmem_rdata, D2);
        drive_req(1'b1, 1'b0, 16'h0040, 128'h0);
        await_resp(1'b0, 1'b0);
        release_req();
        chk("both_write_done", pmem_rdata, D4);
        chk("proto_err_sticky", proto_err, 1'b1);
        do_reset();
        chk("proto_err_reset", proto_err, 1'b0);

        // Index aliasing: 0x0100 and 0x0000 share line 0.
        drive_req(1'b0, 1'b1, 16'h0100, D5);
        await_resp(1'b0, 1'b0);
        release_req();
        drive_req(1'b1, 1'b0, 16'h0000, 128'h0);
        await_resp(1'b0, 1'b0);
        release_req();
        chk("alias_read", pmem_rdata, D5);

        // Request withdrawn mid-flight: completes, flags proto_err.
        drive_req(1'b0, 1'b1, 16'h0070, D6);
        await_resp(1'b1, 1'b0);
        release_req();
        chk("withdraw_proto_err", proto_err, 1'b1);
        drive_req(1'b1, 1'b0, 16'h0070, 128'h0);
        await_resp(1'b0, 1'b0);
        release_req();
        chk("withdraw_write_done", pmem_rdata, D6);
        do_reset();

        // Read held across RESP: one pulse, re-accepted from IDLE.
        drive_req(1'b1, 1'b0, 16'h0030, 128'h0);
        await_resp(1'b0, 1'b0);
        @(negedge clk);
        chk("held_single_pulse", pmem_resp, 1'b0);
        chk("held_idle_gap", busy, 1'b0);
        drive_req(1'b1, 1'b0, 16'h0030, 128'h0);
        await_resp(1'b0, 1'b0);
        release_req();
        chk("held_second_rdata", pmem_rdata, D1);
        repeat (4) @(negedge clk);
        chk("held_proto_err", proto_err, 1'b0);

        chk("queue_drained", 128'(exp_q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
